// File: rtl/comm_frame_gate.sv
// Receive front-end gate: finds a burst by sliding-window energy, drops the
// preamble and cyclic prefixes, and forwards NSYM payload symbols of 64 samples.
`timescale 1ns/1ps

module comm_frame_gate #(
  parameter int unsigned THRESH   = 400,
  parameter int unsigned PRE_LEN  = 64,
  parameter int unsigned CP_LEN   = 16,
  parameter int unsigned NSYM     = 8,
  parameter int unsigned HOLD_LEN = 32
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] adc1_i,
  input  logic [7:0] adc2_i,
  input  logic       adc_strobe,
  output logic [7:0] ad1,
  output logic [7:0] ad2,
  output logic       ad_valid,
  output logic       frame_start,
  output logic       busy,
  output logic [7:0] sym_idx
);

  localparam int unsigned DW      = 8;
  localparam int unsigned MAG_W   = 9;
  localparam int unsigned SUM_W   = 13;
  localparam int unsigned WIN_LEN = 16;
  localparam int unsigned SYM_LEN = 64;
  localparam int unsigned HIST_W  = WIN_LEN * MAG_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_CP,
    S_SYM,
    S_HOLD
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DW-1:0]     r_cnt;
  logic [DW-1:0]     w_cnt_nxt;
  logic [DW-1:0]     w_cnt_inc;
  logic [DW-1:0]     r_sym_idx;
  logic [DW-1:0]     w_sym_nxt;
  logic [DW-1:0]     r_ad1;
  logic [DW-1:0]     r_ad2;
  logic [DW-1:0]     w_ad1_nxt;
  logic [DW-1:0]     w_ad2_nxt;
  logic              r_valid;
  logic              w_valid_nxt;
  logic              r_fs;
  logic              w_fs_nxt;
  logic              r_busy;

  logic [HIST_W-1:0] r_hist;
  logic [SUM_W-1:0]  r_sum;
  logic [SUM_W-1:0]  w_sum_upd;
  logic [DW-1:0]     w_mag_i;
  logic [DW-1:0]     w_mag_q;
  logic [MAG_W-1:0]  w_mag;
  logic [MAG_W-1:0]  w_oldest;
  logic              w_trig;

  // Offset-binary magnitude |x-128|; 0 maps to 128, which still fits 8 bits.
  assign w_mag_i   = (adc1_i >= 8'd128) ? (adc1_i - 8'd128) : (8'd128 - adc1_i);
  assign w_mag_q   = (adc2_i >= 8'd128) ? (adc2_i - 8'd128) : (8'd128 - adc2_i);
  assign w_mag     = MAG_W'(w_mag_i) + MAG_W'(w_mag_q);
  assign w_oldest  = r_hist[HIST_W-1 -: MAG_W];
  assign w_sum_upd = r_sum + SUM_W'(w_mag) - SUM_W'(w_oldest);
  assign w_trig    = adc_strobe && (w_sum_upd >= SUM_W'(THRESH));
  assign w_cnt_inc = r_cnt + 8'd1;

  // Energy window advances on every strobe regardless of state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_hist <= '0;
      r_sum  <= '0;
    end else if (adc_strobe) begin
      r_hist <= {r_hist[HIST_W-MAG_W-1:0], w_mag};
      r_sum  <= w_sum_upd;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_sym_idx <= '0;
      r_ad1     <= 8'd128;
      r_ad2     <= 8'd128;
      r_valid   <= 1'b0;
      r_fs      <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_sym_idx <= w_sym_nxt;
      r_ad1     <= w_ad1_nxt;
      r_ad2     <= w_ad2_nxt;
      r_valid   <= w_valid_nxt;
      r_fs      <= w_fs_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sym_nxt   = r_sym_idx;
    w_ad1_nxt   = r_ad1;
    w_ad2_nxt   = r_ad2;
    w_valid_nxt = 1'b0;
    w_fs_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_trig) begin
          w_fs_nxt = 1'b1;
          // The trigger sample is the first preamble sample.
          if (PRE_LEN <= 1) begin
            w_state_nxt = S_CP;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = S_PRE;
            w_cnt_nxt   = 8'd1;
          end
        end
      end
      S_PRE: begin
        if (adc_strobe) begin
          if (w_cnt_inc == 8'(PRE_LEN)) begin
            w_state_nxt = S_CP;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      S_CP: begin
        if (adc_strobe) begin
          if (w_cnt_inc == 8'(CP_LEN)) begin
            w_state_nxt = S_SYM;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      S_SYM: begin
        if (adc_strobe) begin
          w_valid_nxt = 1'b1;
          w_ad1_nxt   = adc1_i;
          w_ad2_nxt   = adc2_i;
          if (w_cnt_inc == 8'(SYM_LEN)) begin
            w_cnt_nxt = '0;
            if (r_sym_idx == 8'(NSYM - 1)) begin
              w_state_nxt = S_HOLD;
              w_sym_nxt   = '0;
            end else begin
              w_state_nxt = S_CP;
              w_sym_nxt   = r_sym_idx + 8'd1;
            end
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      S_HOLD: begin
        if (HOLD_LEN == 0) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (adc_strobe) begin
          if (w_cnt_inc == 8'(HOLD_LEN)) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign ad1         = r_ad1;
  assign ad2         = r_ad2;
  assign ad_valid    = r_valid;
  assign frame_start = r_fs;
  assign busy        = r_busy;
  assign sym_idx     = r_sym_idx;

endmodule

// File: tb/tb_comm_frame_gate.sv
// Bench for comm_frame_gate: trigger-point vector table on two threshold
// settings, plus scoreboarded bursts (continuous, gapped, reset, re-arm).
`timescale 1ns/1ps

module tb_comm_frame_gate;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] adc1_i;
  logic [7:0] adc2_i;
  logic       adc_strobe;

  logic [7:0] a_ad1, a_ad2, a_sym_idx;
  logic       a_ad_valid, a_frame_start, a_busy;
  logic [7:0] b_ad1, b_ad2, b_sym_idx;
  logic       b_ad_valid, b_frame_start, b_busy;

  comm_frame_gate dut_a (
    .CLK(CLK), .RST(RST), .adc1_i(adc1_i), .adc2_i(adc2_i), .adc_strobe(adc_strobe),
    .ad1(a_ad1), .ad2(a_ad2), .ad_valid(a_ad_valid), .frame_start(a_frame_start),
    .busy(a_busy), .sym_idx(a_sym_idx)
  );

  comm_frame_gate #(.THRESH(512)) dut_b (
    .CLK(CLK), .RST(RST), .adc1_i(adc1_i), .adc2_i(adc2_i), .adc_strobe(adc_strobe),
    .ad1(b_ad1), .ad2(b_ad2), .ad_valid(b_ad_valid), .frame_start(b_frame_start),
    .busy(b_busy), .sym_idx(b_sym_idx)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model of dut_a (THRESH=400, default framing)
  int         m_hist [16];
  int         m_sum;
  bit         m_active;
  int         m_k;
  logic [7:0] q_i[$];
  logic [7:0] q_q[$];
  int         last_i, last_q;
  bit         exp_fs, exp_valid;
  bit         chk_en;
  int         fs_cnt = 0;
  int         valid_cnt = 0;
  int         sym_max;

  typedef struct {
    int i;
    int q;
    int exp_a;
    int exp_b;
  } trig_vec_t;

  trig_vec_t tv [9];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic int exp_sym();
    if (!m_active || m_k < 143 || m_k >= 703) return 0;
    return (m_k - 143) / 80 + 1;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 16; j++) m_hist[j] = 0;
    m_sum    = 0;
    m_active = 1'b0;
    m_k      = 0;
    q_i.delete();
    q_q.delete();
    last_i   = 128;
    last_q   = 128;
  endtask

  // Drive one cycle, advance the model, then check outputs just after the edge.
  task automatic drive(input int di, input int dq, input bit stb);
    int m;
    int ei, eq;
    adc1_i     = 8'(di);
    adc2_i     = 8'(dq);
    adc_strobe = stb;
    exp_fs     = 1'b0;
    exp_valid  = 1'b0;
    if (stb) begin
      m     = iabs(di - 128) + iabs(dq - 128);
      m_sum = m_sum + m - m_hist[15];
      for (int j = 15; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = m;
      if (!m_active) begin
        if (m_sum >= 400) begin
          m_active = 1'b1;
          m_k      = 0;
          exp_fs   = 1'b1;
        end
      end else begin
        m_k++;
        if (m_k >= 80 && m_k <= 703 && ((m_k - 80) % 80) < 64) begin
          exp_valid = 1'b1;
          q_i.push_back(8'(di));
          q_q.push_back(8'(dq));
        end
        if (m_k == 735) m_active = 1'b0;
      end
    end
    @(posedge CLK);
    #1;
    if (a_frame_start) fs_cnt++;
    if (a_ad_valid) valid_cnt++;
    if (int'(a_sym_idx) > sym_max) sym_max = int'(a_sym_idx);
    if (chk_en) begin
      check("frame_start", int'(a_frame_start), int'(exp_fs));
      check("ad_valid", int'(a_ad_valid), int'(exp_valid));
      check("busy", int'(a_busy), int'(m_active));
      check("sym_idx", int'(a_sym_idx), exp_sym());
      if (a_ad_valid) begin
        if (q_i.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_underflow: got a valid sample (%0d,%0d), expected none", a_ad1, a_ad2);
        end else begin
          ei = int'(q_i.pop_front());
          eq = int'(q_q.pop_front());
          check("ad1", int'(a_ad1), ei);
          check("ad2", int'(a_ad2), eq);
          last_i = ei;
          last_q = eq;
        end
      end else begin
        check("ad1_hold", int'(a_ad1), last_i);
        check("ad2_hold", int'(a_ad2), last_q);
      end
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    adc1_i = 8'd128;
    adc2_i = 8'd128;
    adc_strobe = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    model_reset();
  endtask

  // One burst: quiet lead-in, step to trigger, varied payload, quiet tail.
  task automatic run_burst(input bit gaps, input int stop_k, input string tag);
    int  v0, f0, di, dq;
    bit  trig, done;
    v0 = valid_cnt;
    f0 = fs_cnt;
    trig = 1'b0;
    done = 1'b0;
    sym_max = 0;
    for (int n = 0; n < 20; n++) begin
      drive(128, 128, 1'b1);
      if (gaps) drive(77, 200, 1'b0);
    end
    for (int s = 0; s < 3000 && !done; s++) begin
      if (!trig) begin
        di = 160; dq = 128;
      end else if (m_k + 1 <= 703) begin
        di = 150 + ((m_k + 1) * 7) % 100;
        dq = 20 + ((m_k + 1) * 13) % 200;
      end else begin
        di = 128; dq = 128;
      end
      drive(di, dq, 1'b1);
      if (gaps) drive(77, 200, 1'b0);
      if (m_active) trig = 1'b1;
      if (trig && (!m_active || (stop_k >= 0 && m_k == stop_k))) done = 1'b1;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: burst did not complete, k=%0d, expected completion", tag, m_k);
    end
    if (stop_k < 0) begin
      for (int n = 0; n < 40; n++) drive(128, 128, 1'b1);
      check({tag, "_valid_total"}, valid_cnt - v0, 512);
      check({tag, "_frame_starts"}, fs_cnt - f0, 1);
      check({tag, "_sym_max"}, sym_max, 7);
      check({tag, "_sb_empty"}, q_i.size(), 0);
    end
  endtask

  initial begin
    int fa, fb, v0, f0;
    tv[0] = '{160, 128, 13, 16};
    tv[1] = '{128,  96, 13, 16};
    tv[2] = '{ 96, 160,  7,  8};
    tv[3] = '{  0,   0,  2,  2};
    tv[4] = '{255, 255,  2,  3};
    tv[5] = '{153, 128, 16,  0};
    tv[6] = '{152, 128,  0,  0};
    tv[7] = '{100, 156,  8, 10};
    tv[8] = '{130, 127,  0,  0};

    chk_en = 1'b0;
    do_reset();
    check("rst_ad1", int'(a_ad1), 128);
    check("rst_ad2", int'(a_ad2), 128);
    check("rst_valid", int'(a_ad_valid), 0);
    check("rst_fs", int'(a_frame_start), 0);
    check("rst_busy", int'(a_busy), 0);
    check("rst_sym", int'(a_sym_idx), 0);
    check("rst_b_ad", int'({b_ad1, b_ad2}), 16'h8080);
    check("rst_b_flags", int'({b_ad_valid, b_frame_start, b_busy}), 0);
    check("rst_b_sym", int'(b_sym_idx), 0);

    // Trigger point per input level, for THRESH 400 (a) and 512 (b)
    foreach (tv[n]) begin
      do_reset();
      fa = 0;
      fb = 0;
      for (int s = 0; s < 20; s++) drive(128, 128, 1'b1);
      for (int s = 1; s <= 20; s++) begin
        drive(tv[n].i, tv[n].q, 1'b1);
        if (a_frame_start && fa == 0) fa = s;
        if (b_frame_start && fb == 0) fb = s;
      end
      check($sformatf("trig_a_%0d", n), fa, tv[n].exp_a);
      check($sformatf("trig_b_%0d", n), fb, tv[n].exp_b);
    end

    // Idle noise
    do_reset();
    chk_en = 1'b1;
    f0 = fs_cnt;
    for (int s = 0; s < 1000; s++) drive(128, 128, 1'b1);
    for (int s = 0; s < 50; s++) drive(130, 127, 1'b1);
    check("idle_no_trigger", fs_cnt - f0, 0);

    // Continuous and gapped bursts
    do_reset();
    run_burst(1'b0, -1, "step");
    do_reset();
    run_burst(1'b1, -1, "gaps");

    // Reset during symbol 3, sample 20
    do_reset();
    run_burst(1'b0, 340, "mid");
    RST = 1'b1;
    #2;
    check("mid_rst_ad1", int'(a_ad1), 128);
    check("mid_rst_ad2", int'(a_ad2), 128);
    check("mid_rst_valid", int'(a_ad_valid), 0);
    check("mid_rst_busy", int'(a_busy), 0);
    check("mid_rst_sym", int'(a_sym_idx), 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    model_reset();
    run_burst(1'b0, -1, "after_rst");

    // Re-arm: two bursts without reset
    do_reset();
    v0 = valid_cnt;
    f0 = fs_cnt;
    run_burst(1'b0, -1, "rearm1");
    check("rearm_sym_between", int'(a_sym_idx), 0);
    run_burst(1'b0, -1, "rearm2");
    check("rearm_valid_total", valid_cnt - v0, 1024);
    check("rearm_frame_starts", fs_cnt - f0, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/comm_frame_gate.md
# comm_frame_gate

Receive front-end stage that sits directly upstream of `comm_recv` and drives its `ad1`/`ad2`/`ad_valid` inputs. It watches the raw offset-binary ADC I/Q stream, detects the start of a burst by sliding-window energy, and discards the preamble and each cyclic prefix. Only the payload samples of each OFDM symbol are forwarded, in gap-free-in-order runs of 64, so the downstream FFT receives exactly `NSYM` aligned symbols per burst.

## Interface
Parameters:
- `THRESH`, 400: window-energy trigger level; trigger when sum ≥ THRESH (13-bit compare).
- `PRE_LEN`, 64: preamble samples dropped, counting the trigger sample.
- `CP_LEN`, 16: cyclic-prefix samples dropped before every symbol; range 1..255.
- `NSYM`, 8: payload symbols per burst; range 1..255.
- `HOLD_LEN`, 32: samples ignored after the last symbol before re-arming; range 0..255.

Ports:
- `CLK`, in, 1: clock. One clock; all logic on the rising edge.
- `RST`, in, 1: reset, asynchronous, active-high.
- `adc1_i`, in, 8: I sample, offset binary, 128 = zero.
- `adc2_i`, in, 8: Q sample, offset binary.
- `adc_strobe`, in, 1: the sample pair is valid this cycle; may be held high or have gaps.
- `ad1`, out, 8: registered I output to `comm_recv`.
- `ad2`, out, 8: registered Q output.
- `ad_valid`, out, 1: `ad1`/`ad2` hold a payload sample.
- `frame_start`, out, 1: one-cycle pulse on detection.
- `busy`, out, 1: high in any state other than IDLE.
- `sym_idx`, out, 8: index of the current or next symbol, 0..NSYM-1.

## Operation
- Magnitude per sample: m = |adc1_i−128| + |adc2_i−128|, 9 bits, range 0..256.
- Energy window: a 16-entry shift history of m that advances only on `adc_strobe`.
  - The running sum is updated as sum + m_new − m_oldest, 13 bits, and never saturates.
  - The history and sum clear to 0 on reset.
  - The window updates in every state.
- The trigger compare uses the updated sum, including the current sample.
- State machine. One counter `cnt` (8 bits) counts accepted strobes; every transition below happens only on a strobe cycle.
  - IDLE → PRE when the updated sum ≥ THRESH. Set cnt=1 and pulse `frame_start`.
  - PRE: increment cnt. When the sample making cnt==PRE_LEN is consumed, go to CP with cnt=0.
  - CP: drop CP_LEN samples, then go to SYM with cnt=0.
  - SYM: forward each sample (`ad_valid`=1). After the 64th sample:
    - if sym_idx==NSYM−1, go to HOLD and set sym_idx=0;
    - else increment sym_idx and go to CP.
  - HOLD: drop HOLD_LEN samples, then go to IDLE. If HOLD_LEN=0, go HOLD→IDLE on the next cycle without consuming a sample.
- No re-trigger is possible outside IDLE. The energy compare is ignored in all other states.
- A non-strobe cycle changes nothing except that `ad_valid` and `frame_start` drop to 0.

## Timing
- Reset values: `ad1`=`ad2`=8'd128, `ad_valid`=0, `frame_start`=0, `busy`=0, `sym_idx`=0; state IDLE; cnt=0.
- Latency: a forwarded sample on strobe cycle t appears on `ad1`/`ad2` with `ad_valid`=1 at cycle t+1.
- `ad1`/`ad2` hold their last value while `ad_valid`=0.
- `frame_start` is high in cycle t+1 after the triggering strobe at t. `busy` rises in the same cycle.
- `busy` falls in the cycle after the HOLD→IDLE transition.
- Strobe gaps pass straight through. `ad_valid` has the same gap pattern as `adc_strobe` during SYM, and the sample count is unaffected.
- No backpressure: `comm_recv`'s FIFO absorbs bursts. Upstream must not exceed one sample per clock.
- Asserting `RST` mid-burst immediately returns all outputs and state to reset values. After release, the block re-arms in IDLE with an empty window.
- Per burst, `ad_valid` is high for exactly NSYM·64 cycles.

## Test plan
- **Idle noise:** 1000 strobes of (128,128), then (130,127). Required: window sum stays ≤48, `frame_start` never fires, `ad_valid`=0, `busy`=0.
- **Step burst, default parameters:** continuous strobe; 20 quiet samples, then constant (160,128).
  - Trigger on the 13th high sample (sum 416 ≥ 400; 12 samples give 384).
  - First `ad_valid` follows the sample 80 strobes after the trigger.
  - Then 8 runs of 64 valid samples, each run separated by 16 invalid cycles.
  - `busy` stays high through HOLD; 512 valid samples in total.
- **Threshold equality:** THRESH=512 with input (160,128). Required: trigger on exactly the 16th high sample (sum 512).
- **Strobe gaps:** same burst with `adc_strobe` toggling 1/0. Required: `ad_valid` only on the cycle after a strobe, still 512 samples, and the sample order matches the non-gapped run.
- **Reset mid-symbol:** pulse `RST` during symbol 3, sample 20. Required: outputs return to 128/0 immediately; the next burst of 512 samples is forwarded correctly.
- **Re-arm:** two bursts separated by quiet samples longer than HOLD_LEN. Required: two `frame_start` pulses, 1024 valid samples, and `sym_idx` wraps 7→0 between the bursts.
